writeback_stage: RTL and testbench

MEM/WB pipeline register and writeback formatter for the five-stage MIPS core. Sits directly upstream of the general-purpose register file.
- Latches the retiring instruction from the MEM stage.
- Selects and formats the writeback value (ALU result, sign- or zero-extended load, or link address).
- Drives the register-file write port (data, enable, destination, PC for the trace display).
- Keeps a retired-instruction counter and a sticky misaligned-load error.

---
 rtl/writeback_stage.sv | 149 ++++++++++++++
 tb/tb_writeback_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register and writeback formatter
module writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [1:0]  mem_wb_sel,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [2:0]  mem_load_type,
  input  logic        stall,
  input  logic        flush,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_write_data,
  output logic        wb_write_enabled,
  output logic [31:0] retired_count,
  output logic        misaligned_err,
  output logic [31:0] misaligned_pc
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic [1:0]  off;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_fmt;
  logic [31:0] fmt_value;
  logic        is_half;
  logic        is_word;
  logic        misaligned;

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] count_q, count_d;
  logic        err_q, err_d;
  logic [31:0] mpc_q, mpc_d;

  assign off = mem_alu_result[1:0];

  // Pick the addressed little-endian lane and extend it per load type
  always_comb begin
    case (off)
      2'd0:    byte_lane = mem_load_data[7:0];
      2'd1:    byte_lane = mem_load_data[15:8];
      2'd2:    byte_lane = mem_load_data[23:16];
      default: byte_lane = mem_load_data[31:24];
    endcase
    half_lane = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    case (mem_load_type)
      LT_LB:   load_fmt = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU:  load_fmt = {24'd0, byte_lane};
      LT_LH:   load_fmt = {{16{half_lane[15]}}, half_lane};
      LT_LHU:  load_fmt = {16'd0, half_lane};
      default: load_fmt = mem_load_data;
    endcase
  end

  // Writeback source mux and misalignment detection; unknown load types behave as lw
  always_comb begin
    case (mem_wb_sel)
      SEL_LOAD: fmt_value = load_fmt;
      SEL_LINK: fmt_value = mem_pc + 32'd8;
      default:  fmt_value = mem_alu_result;
    endcase
    is_half    = (mem_load_type == LT_LH) || (mem_load_type == LT_LHU);
    is_word    = !is_half && (mem_load_type != LT_LB) && (mem_load_type != LT_LBU);
    misaligned = mem_valid && (mem_wb_sel == SEL_LOAD) &&
                 ((is_half && off[0]) || (is_word && (off != 2'd0)));
  end

  // Next-state: stall holds everything, flush inserts a bubble, otherwise capture
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    count_d = count_q;
    err_d   = err_q;
    mpc_d   = mpc_q;
    if (!stall) begin
      pc_d = mem_pc;
      if (flush || !mem_valid) begin
        valid_d = 1'b0;
        rd_d    = 5'd0;
        wdata_d = 32'd0;
        we_d    = 1'b0;
      end else begin
        valid_d = 1'b1;
        rd_d    = mem_rd;
        wdata_d = fmt_value;
        we_d    = mem_reg_write && (mem_rd != 5'd0) && !misaligned;
        count_d = count_q + 32'd1;
        if (misaligned && !err_q) begin
          err_d = 1'b1;
          mpc_d = mem_pc;
        end
      end
    end
  end

  // Stage registers; asynchronous reset drops any in-flight instruction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      rd_q    <= 5'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      count_q <= 32'd0;
      err_q   <= 1'b0;
      mpc_q   <= 32'd0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      count_q <= count_d;
      err_q   <= err_d;
      mpc_q   <= mpc_d;
    end
  end

  assign wb_valid         = valid_q;
  assign wb_pc            = pc_q;
  assign wb_rd            = rd_q;
  assign wb_write_data    = wdata_q;
  assign wb_write_enabled = we_q;
  assign retired_count    = count_q;
  assign misaligned_err   = err_q;
  assign misaligned_pc    = mpc_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;

  localparam logic [31:0] RESET_PC = 32'h00003000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = 32'd0;
  logic [4:0]  mem_rd = 5'd0;
  logic        mem_reg_write = 1'b0;
  logic [1:0]  mem_wb_sel = 2'd0;
  logic [31:0] mem_alu_result = 32'd0;
  logic [31:0] mem_load_data = 32'd0;
  logic [2:0]  mem_load_type = 3'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic        wb_write_enabled;
  logic [31:0] retired_count;
  logic        misaligned_err;
  logic [31:0] misaligned_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic        m_valid, m_we, m_err, m_dchk;
  logic [31:0] m_pc, m_wd, m_count, m_mpc;
  logic [4:0]  m_rd;

  writeback_stage #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_load_type(mem_load_type), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_write_data(wb_write_data), .wb_write_enabled(wb_write_enabled),
    .retired_count(retired_count), .misaligned_err(misaligned_err),
    .misaligned_pc(misaligned_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_value(input logic [1:0] sel, input logic [2:0] lt,
                                            input logic [31:0] alu, input logic [31:0] ld,
                                            input logic [31:0] pc);
    int o = int'(alu[1:0]);
    logic [31:0] b = (ld >> (8 * o)) & 32'hFF;
    logic [31:0] h = (ld >> (16 * (o / 2))) & 32'hFFFF;
    if (sel == 2'd1) begin
      if (lt == 3'd1) return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      if (lt == 3'd2) return b;
      if (lt == 3'd3) return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      if (lt == 3'd4) return h;
      return ld;
    end
    if (sel == 2'd2) return pc + 32'd8;
    return alu;
  endfunction

  function automatic logic ref_misaligned(input logic v, input logic [1:0] sel,
                                          input logic [2:0] lt, input logic [31:0] alu);
    int o = int'(alu[1:0]);
    if (!v || sel != 2'd1) return 1'b0;
    if (lt == 3'd1 || lt == 3'd2) return 1'b0;
    if (lt == 3'd3 || lt == 3'd4) return (o % 2) == 1;
    return o != 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_err = 0; m_dchk = 1;
    m_pc = RESET_PC; m_wd = 0; m_count = 0; m_mpc = 0; m_rd = 0;
  endtask

  task automatic model_step();
    logic mis;
    if (stall) return;
    m_pc = mem_pc;
    if (flush || !mem_valid) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_wd = 0; m_dchk = 1;
      return;
    end
    mis = ref_misaligned(mem_valid, mem_wb_sel, mem_load_type, mem_alu_result);
    m_valid = 1;
    m_rd = mem_rd;
    m_wd = ref_value(mem_wb_sel, mem_load_type, mem_alu_result, mem_load_data, mem_pc);
    m_dchk = !mis;
    m_we = mem_reg_write && (mem_rd != 0) && !mis;
    m_count = m_count + 1;
    if (mis && !m_err) begin
      m_err = 1;
      m_mpc = mem_pc;
    end
  endtask

  task automatic tick();
    if (reset) model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_insn(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                          input logic rw, input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] ld, input logic [2:0] lt);
    mem_valid = v; mem_pc = pc; mem_rd = rd; mem_reg_write = rw;
    mem_wb_sel = sel; mem_alu_result = alu; mem_load_data = ld; mem_load_type = lt;
  endtask

  task automatic randomize_inputs();
    set_insn(1'($urandom), $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
             $urandom, $urandom, 3'($urandom));
  endtask

  task automatic test_reset();
    reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1'($urandom); flush = 1'($urandom);
      tick();
      n_cmp++;
      if (wb_pc !== RESET_PC || wb_valid !== 0 || wb_rd !== 0 || wb_write_data !== 0 ||
          wb_write_enabled !== 0 || retired_count !== 0 || misaligned_err !== 0 ||
          misaligned_pc !== 0) begin
        n_bad++;
        $display("FAIL reset_hold: pc=%h v=%b rd=%0d wd=%h we=%b cnt=%0d err=%b mpc=%h, required pc=%h and all else 0",
                 wb_pc, wb_valid, wb_rd, wb_write_data, wb_write_enabled, retired_count,
                 misaligned_err, misaligned_pc, RESET_PC);
      end
    end
    stall = 0; flush = 0;
    reset = 1;
    set_insn(1, 32'h3000, 5'd2, 1, 2'd0, 32'h11, 32'h0, 3'd0);
    tick();
    n_cmp++;
    if (retired_count !== 32'd1) begin
      n_bad++;
      $display("FAIL reset_first_count: got %0d, required 1", retired_count);
    end
  endtask

  task automatic test_alu();
    set_insn(1, 32'h3004, 5'd8, 1, 2'b00, 32'h12345678, 32'hA5A5A5A5, 3'd0);
    tick();
    n_cmp++;
    if (wb_write_enabled !== 1 || wb_rd !== 5'd8 || wb_write_data !== 32'h12345678 ||
        wb_pc !== 32'h3004 || wb_valid !== 1) begin
      n_bad++;
      $display("FAIL alu_wb: we=%b rd=%0d wd=%h pc=%h v=%b, required 1 8 12345678 00003004 1",
               wb_write_enabled, wb_rd, wb_write_data, wb_pc, wb_valid);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lts [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0]  offs[5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps[5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      set_insn(1, 32'h3008 + 32'(4 * i), 5'd5, 1, 2'b01, {30'h400, offs[i]}, 32'h80FF7F01, lts[i]);
      tick();
      n_cmp++;
      if (wb_write_data !== exps[i] || wb_write_enabled !== 1) begin
        n_bad++;
        $display("FAIL load_fmt[%0d]: wd=%h we=%b, required wd=%h we=1",
                 i, wb_write_data, wb_write_enabled, exps[i]);
      end
    end
  endtask

  task automatic test_link();
    logic [31:0] c0;
    set_insn(1, 32'h0000301C, 5'd31, 1, 2'b10, 32'h0, 32'h0, 3'd0);
    tick();
    n_cmp++;
    if (wb_write_data !== 32'h00003024 || wb_write_enabled !== 1 || wb_rd !== 5'd31) begin
      n_bad++;
      $display("FAIL link: wd=%h we=%b rd=%0d, required 00003024 1 31",
               wb_write_data, wb_write_enabled, wb_rd);
    end
    c0 = retired_count;
    mem_rd = 5'd0;
    tick();
    n_cmp++;
    if (wb_write_enabled !== 0 || wb_valid !== 1 || retired_count !== c0 + 32'd1) begin
      n_bad++;
      $display("FAIL link_rd0: we=%b v=%b cnt=%0d, required 0 1 %0d",
               wb_write_enabled, wb_valid, retired_count, c0 + 32'd1);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] c0;
    set_insn(1, 32'h3100, 5'd9, 1, 2'b00, 32'hDEADBEEF, 32'h0, 3'd0);
    tick();
    c0 = retired_count;
    stall = 1; flush = 1;
    for (int i = 0; i < 2; i++) begin
      set_insn(1, 32'h3200 + 32'(i), 5'd3, 1, 2'b00, 32'h55, 32'h0, 3'd0);
      tick();
      n_cmp++;
      if (wb_valid !== 1 || wb_pc !== 32'h3100 || wb_rd !== 5'd9 ||
          wb_write_data !== 32'hDEADBEEF || wb_write_enabled !== 1 || retired_count !== c0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h rd=%0d wd=%h we=%b cnt=%0d, required 1 00003100 9 deadbeef 1 %0d",
                 i, wb_valid, wb_pc, wb_rd, wb_write_data, wb_write_enabled, retired_count, c0);
      end
    end
    stall = 0;
    set_insn(1, 32'h3300, 5'd4, 1, 2'b00, 32'h77, 32'h0, 3'd0);
    tick();
    flush = 0;
    n_cmp++;
    if (wb_valid !== 0 || wb_write_enabled !== 0 || wb_rd !== 0 || wb_write_data !== 0 ||
        wb_pc !== 32'h3300 || retired_count !== c0) begin
      n_bad++;
      $display("FAIL flush_bubble: v=%b we=%b rd=%0d wd=%h pc=%h cnt=%0d, required 0 0 0 0 00003300 %0d",
               wb_valid, wb_write_enabled, wb_rd, wb_write_data, wb_pc, retired_count, c0);
    end
  endtask

  task automatic test_misaligned();
    set_insn(1, 32'h3040, 5'd6, 1, 2'b01, 32'h1002, 32'h12345678, 3'd0);
    tick();
    n_cmp++;
    if (wb_write_enabled !== 0 || wb_valid !== 1 || misaligned_err !== 1 ||
        misaligned_pc !== 32'h3040 || retired_count !== m_count) begin
      n_bad++;
      $display("FAIL misaligned_lw: we=%b v=%b err=%b mpc=%h cnt=%0d, required 0 1 1 00003040 %0d",
               wb_write_enabled, wb_valid, misaligned_err, misaligned_pc, retired_count, m_count);
    end
    set_insn(1, 32'h3050, 5'd7, 1, 2'b01, 32'h1001, 32'h12345678, 3'd3);
    tick();
    n_cmp++;
    if (wb_write_enabled !== 0 || misaligned_err !== 1 || misaligned_pc !== 32'h3040) begin
      n_bad++;
      $display("FAIL misaligned_sticky: we=%b err=%b mpc=%h, required 0 1 00003040",
               wb_write_enabled, misaligned_err, misaligned_pc);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 3) == 0) mem_alu_result[1:0] = 2'd0;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      tick();
      n_cmp++;
      if (wb_valid !== m_valid || wb_pc !== m_pc || wb_rd !== m_rd ||
          wb_write_enabled !== m_we || retired_count !== m_count ||
          misaligned_err !== m_err || misaligned_pc !== m_mpc) begin
        n_bad++;
        $display("FAIL rnd_ctrl[%0d]: v=%b pc=%h rd=%0d we=%b cnt=%0d err=%b mpc=%h, required %b %h %0d %b %0d %b %h",
                 i, wb_valid, wb_pc, wb_rd, wb_write_enabled, retired_count, misaligned_err,
                 misaligned_pc, m_valid, m_pc, m_rd, m_we, m_count, m_err, m_mpc);
      end
      if (m_dchk) begin
        n_cmp++;
        if (wb_write_data !== m_wd) begin
          n_bad++;
          $display("FAIL rnd_data[%0d]: wd=%h, required %h", i, wb_write_data, m_wd);
        end
      end
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_async_reset();
    set_insn(1, 32'h3400, 5'd10, 1, 2'b00, 32'hCAFEF00D, 32'h0, 3'd0);
    tick();
    #2;
    reset = 0;
    #1;
    n_cmp++;
    if (wb_valid !== 0 || wb_write_enabled !== 0 || wb_rd !== 0 || wb_write_data !== 0 ||
        wb_pc !== RESET_PC || retired_count !== 0 || misaligned_err !== 0 || misaligned_pc !== 0) begin
      n_bad++;
      $display("FAIL async_reset: v=%b we=%b rd=%0d wd=%h pc=%h cnt=%0d err=%b mpc=%h, required pc=%h and all else 0",
               wb_valid, wb_write_enabled, wb_rd, wb_write_data, wb_pc, retired_count,
               misaligned_err, misaligned_pc, RESET_PC);
    end
    model_reset();
    tick();
    n_cmp++;
    if (wb_write_enabled !== 0 || retired_count !== 0) begin
      n_bad++;
      $display("FAIL async_reset_hold: we=%b cnt=%0d, required 0 0", wb_write_enabled, retired_count);
    end
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_link();
    test_stall_flush();
    test_misaligned();
    test_random(300);
    test_async_reset();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
